uart_ctrl: RTL and testbench

Memory-mapped controller that sequences the `uart` core for the CPU. It buffers outbound bytes in a TX FIFO and feeds them to the core through its `tx_start`/`tx_busy` handshake, and captures `rx_valid` bytes into an RX FIFO. CPU load/store traffic reaches the block through a four-register window. It sits between the CPU data bus decoder and the `uart` instance, and all state advances only on `clk_cpu`-enabled cycles.

---
 rtl/uart_ctrl_if.sv | 28 ++
 rtl/uart_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_if.sv
// Bus and core-side signal bundle for uart_ctrl.
// Ports: sel/we/addr/wdata/rdata form the CPU register window; tx_byte/tx_start/tx_busy
// and rx_byte/rx_valid connect to the uart core; irq is the level interrupt to the CPU.
interface uart_ctrl_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        irq;

  // master: CPU decoder plus uart core (the environment around the controller)
  modport master (
    output sel, we, addr, wdata, tx_busy, rx_byte, rx_valid,
    input  rdata, tx_byte, tx_start, irq
  );

  // slave: the controller itself
  modport slave (
    input  sel, we, addr, wdata, tx_busy, rx_byte, rx_valid,
    output rdata, tx_byte, tx_start, irq
  );
endinterface

// File: rtl/uart_ctrl.sv
// Purpose: CPU register window (DATA/STATUS/CTRL/LEVEL) sequencing a uart core via TX/RX FIFOs.
// Latency: DATA write -> tx_start after 2 enabled cycles; rx byte visible 1 enabled cycle later.
// Backpressure: TX writes dropped when full; RX bytes dropped (sticky overrun) when full.
// Ports: CLK, RST (sync, active-high), clk_cpu (clock enable for all state), bus (uart_ctrl_if.slave).
// Optional feature: define UART_CTRL_IRQ_EN for the CTRL register and registered irq output.
module uart_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clk_cpu,
  uart_ctrl_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_REQ  = 2'd1;
  localparam logic [1:0] TX_WAIT = 2'd2;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;

  logic [1:0]  tx_state;
  logic        rx_overrun;
  logic [1:0]  ctrl;          // bit0 rx_irq_en, bit1 txe_irq_en
  logic [31:0] rdata_c;

  logic [1:0] reg_idx;
  logic       bus_wr, bus_rd;
  logic       tx_full, tx_empty, rx_full, rx_empty, tx_active;
  logic       tx_push, tx_pop, rx_push, rx_pop, rx_drop, ovr_clr;

  assign reg_idx = bus.addr[3:2];
  // Strobes on gated cycles are invisible, so reads there never pop.
  assign bus_wr  = clk_cpu & bus.sel & bus.we;
  assign bus_rd  = clk_cpu & bus.sel & ~bus.we;

  assign tx_full   = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty  = (tx_cnt == '0);
  assign rx_full   = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty  = (rx_cnt == '0);
  assign tx_active = (tx_state != TX_IDLE) | bus.tx_busy;

  assign tx_push = bus_wr & (reg_idx == REG_DATA) & ~tx_full;
  assign tx_pop  = clk_cpu & (tx_state == TX_REQ) & bus.tx_busy & ~tx_empty;
  assign rx_pop  = bus_rd & (reg_idx == REG_DATA) & ~rx_empty;
  // A same-cycle CPU pop frees a slot in a full FIFO, so the byte still lands.
  assign rx_push = clk_cpu & bus.rx_valid & (~rx_full | rx_pop);
  assign rx_drop = clk_cpu & bus.rx_valid & rx_full & ~rx_pop;
  assign ovr_clr = bus_wr & (reg_idx == REG_STATUS) & bus.wdata[4];

  assign bus.tx_byte  = tx_empty ? 8'h00 : tx_mem[tx_rp];
  assign bus.tx_start = (tx_state == TX_REQ);

  // Storage arrays need no reset; emptiness is tracked by the counts.
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= bus.rx_byte;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // TX handshake: request, wait for the core to accept (pop), then wait for
  // it to finish. Re-checking tx_busy in IDLE guarantees idle line time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
    end else if (clk_cpu) begin
      case (tx_state)
        TX_IDLE: if (!tx_empty && !bus.tx_busy) tx_state <= TX_REQ;
        TX_REQ:  if (bus.tx_busy)               tx_state <= TX_WAIT;
        TX_WAIT: if (!bus.tx_busy)              tx_state <= TX_IDLE;
        default:                                tx_state <= TX_IDLE;
      endcase
    end
  end

  // A fresh overrun wins over a clear arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST)          rx_overrun <= 1'b0;
    else if (rx_drop) rx_overrun <= 1'b1;
    else if (ovr_clr) rx_overrun <= 1'b0;
  end

`ifdef UART_CTRL_IRQ_EN
  logic irq_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl  <= 2'b00;
      irq_q <= 1'b0;
    end else if (clk_cpu) begin
      if (bus_wr && reg_idx == REG_CTRL) ctrl <= bus.wdata[1:0];
      irq_q <= (ctrl[0] & ~rx_empty)
             | (ctrl[1] & tx_empty & (tx_state == TX_IDLE))
             | (ctrl[0] & rx_overrun);
    end
  end
  assign bus.irq = irq_q;
`else
  assign ctrl    = 2'b00;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    rdata_c = '0;
    if (bus.sel) begin
      case (reg_idx)
        REG_DATA:   rdata_c = {24'b0, (rx_empty ? 8'h00 : rx_mem[rx_rp])};
        REG_STATUS: rdata_c = {26'b0, tx_active, rx_overrun, rx_full, ~rx_empty, tx_empty, tx_full};
        REG_CTRL:   rdata_c = {30'b0, ctrl};
        REG_LEVEL:  rdata_c = {16'(tx_cnt), 16'(rx_cnt)};
        default:    rdata_c = '0;
      endcase
    end
  end
  assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_uart_ctrl.sv
// Testbench for uart_ctrl: register table, directed TX/RX/overrun/gating/irq sequences,
// and a randomized run scored against queue-based RX/TX models.
// A small core model answers tx_start with a multi-cycle tx_busy pulse and logs bytes.
module tb_uart_ctrl;
  localparam int DEPTH = 16;
`ifdef UART_CTRL_IRQ_EN
  localparam logic [31:0] CTRL_ALL = 32'h3;
`else
  localparam logic [31:0] CTRL_ALL = 32'h0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic clk_cpu;

  uart_ctrl_if u_if();

  uart_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .clk_cpu (clk_cpu),
    .bus     (u_if.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Core model: drives tx_busy on the falling edge; holds busy until its frame
  // time elapses and the controller has withdrawn tx_start.
  logic       core_hold = 1'b0;
  int         core_cnt  = 0;
  logic [7:0] tx_seen[$];

  always @(negedge CLK) begin
    if (RST) begin
      u_if.tx_busy = 1'b0;
      core_cnt     = 0;
    end else if (core_hold) begin
      u_if.tx_busy = 1'b1;
    end else if (u_if.tx_busy) begin
      if (core_cnt > 0) core_cnt--;
      else if (!u_if.tx_start) u_if.tx_busy = 1'b0;
    end else if (u_if.tx_start) begin
      tx_seen.push_back(u_if.tx_byte);
      u_if.tx_busy = 1'b1;
      core_cnt     = 3;
    end
  end

  function automatic logic [31:0] seen_at(input int i);
    if (i < tx_seen.size()) return {24'b0, tx_seen[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    u_if.sel = 1'b1; u_if.we = 1'b1; u_if.addr = a; u_if.wdata = d;
    tick();
    u_if.sel = 1'b0; u_if.we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    u_if.sel = 1'b1; u_if.we = 1'b0; u_if.addr = a;
    #1;
    d = u_if.rdata;
    tick();
    u_if.sel = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    u_if.rx_valid = 1'b1; u_if.rx_byte = b;
    tick();
    u_if.rx_valid = 1'b0;
  endtask

  // Wait until n bytes have been seen and the line is quiet; timeout counts as a failure.
  task automatic wait_tx(input string name, input int n, input int budget);
    int c;
    c = 0;
    while ((tx_seen.size() < n || u_if.tx_busy || u_if.tx_start) && c < budget) begin
      tick();
      c++;
    end
    chk(name, (c < budget), 1);
    tick();
    tick();
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        check;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  m_rx[$];
    logic        m_ovr;
    logic [7:0]  tx_exp[$];
    int          k, op, outstanding;
    logic        en, rv, do_wr, do_clr;
    logic [7:0]  rb;

    u_if.sel = 1'b0; u_if.we = 1'b0; u_if.addr = '0; u_if.wdata = '0;
    u_if.rx_valid = 1'b0; u_if.rx_byte = '0;
    clk_cpu = 1'b1;
    RST = 1'b1;
    repeat (4) tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_tx_start", u_if.tx_start, 0);
    chk("rst_tx_byte", u_if.tx_byte, 0);
    chk("rst_irq", u_if.irq, 0);

    // Register table
    vt[0]  = '{1'b1, 1'b0, 4'h4, 32'h0,         1'b1, 32'h2};
    vt[1]  = '{1'b1, 1'b0, 4'hC, 32'h0,         1'b1, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 4'h8, 32'h0,         1'b1, 32'h0};
    vt[4]  = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 4'h8, 32'h0,         1'b1, CTRL_ALL};
    vt[6]  = '{1'b1, 1'b0, 4'hB, 32'h0,         1'b1, CTRL_ALL};
    vt[7]  = '{1'b1, 1'b1, 4'h8, 32'h0,         1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 4'h8, 32'h0,         1'b1, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 4'h4, 32'h0,         1'b1, 32'h0};
    vt[10] = '{1'b1, 1'b1, 4'hC, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[11] = '{1'b1, 1'b0, 4'hC, 32'h0,         1'b1, 32'h0};
    vt[12] = '{1'b1, 1'b0, 4'h5, 32'h0,         1'b1, 32'h2};
    for (int i = 0; i < 13; i++) begin
      u_if.sel = vt[i].sel; u_if.we = vt[i].we; u_if.addr = vt[i].addr; u_if.wdata = vt[i].wdata;
      #1;
      if (vt[i].check) chk($sformatf("vec%0d", i), u_if.rdata, vt[i].exp);
      tick();
      u_if.sel = 1'b0; u_if.we = 1'b0;
    end

    // Single TX: latency and handshake
    tx_seen.delete();
    wr(4'h0, 32'h55);
    chk("tx_start_after_write", u_if.tx_start, 0);
    chk("tx_byte_head", u_if.tx_byte, 32'h55);
    tick();
    chk("tx_start_req", u_if.tx_start, 1);
    chk("tx_byte_req", u_if.tx_byte, 32'h55);
    tick();
    chk("tx_start_fall", u_if.tx_start, 0);
    rd(4'h4, d);
    chk("single_tx_empty", d[1], 1);
    wait_tx("single_tx_done", 1, 200);
    chk("single_tx_byte", seen_at(0), 32'h55);

    // TX fill against a stalled core
    core_hold = 1'b1;
    tick(); tick();
    tx_seen.delete();
    for (int i = 0; i < 17; i++) wr(4'h0, i);
    rd(4'hC, d);
    chk("fill_level_tx", d[31:16], 16);
    rd(4'h4, d);
    chk("fill_tx_full", d[0], 1);
    core_hold = 1'b0;
    wait_tx("fill_drain", 16, 1000);
    repeat (20) tick();
    chk("fill_tx_count", tx_seen.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("fill_byte%0d", i), seen_at(i), i);

    // Reset mid-frame
    wr(4'h0, 32'h11); wr(4'h0, 32'h22); wr(4'h0, 32'h33);
    k = 0;
    while (!u_if.tx_start && k < 20) begin tick(); k++; end
    chk("midrst_start_seen", u_if.tx_start, 1);
    RST = 1'b1;
    tick();
    chk("midrst_tx_start", u_if.tx_start, 0);
    RST = 1'b0;
    tick();
    rd(4'hC, d);
    chk("midrst_level", d, 0);
    repeat (5) tick();
    chk("midrst_quiet", u_if.tx_start, 0);
    tx_seen.delete();

    // RX order and pointer wrap
    k = 0;
    for (int g = 0; g < 5; g++) begin
      for (int j = 0; j < 4; j++) rx_pulse(8'(8'hA0 + g * 4 + j));
      for (int j = 0; j < 4; j++) begin
        rd(4'h0, d);
        chk($sformatf("rx_order%0d", k), d, 32'(8'hA0 + k));
        k++;
      end
    end
    rd(4'h4, d);
    chk("rx_no_overrun", d[4], 0);

    // Overrun, clear, and pop+push on a full FIFO
    for (int i = 0; i < 17; i++) rx_pulse(8'(8'hC0 + i));
    rd(4'h4, d);
    chk("ovr_set", d[4], 1);
    chk("ovr_full", d[3], 1);
    rd(4'hC, d);
    chk("ovr_level", d[15:0], 16);
    for (int i = 0; i < 16; i++) begin
      rd(4'h0, d);
      chk($sformatf("ovr_data%0d", i), d, 32'(8'hC0 + i));
    end
    rd(4'h0, d);
    chk("ovr_lost_empty", d, 0);
    wr(4'h4, 32'h10);
    rd(4'h4, d);
    chk("ovr_clear", d[4], 0);
    for (int i = 0; i < 16; i++) rx_pulse(8'(8'hE0 + i));
    u_if.sel = 1'b1; u_if.we = 1'b0; u_if.addr = 4'h0;
    u_if.rx_valid = 1'b1; u_if.rx_byte = 8'hF0;
    #1;
    d = u_if.rdata;
    tick();
    u_if.sel = 1'b0; u_if.rx_valid = 1'b0;
    chk("popush_head", d, 32'hE0);
    rd(4'h4, d);
    chk("popush_no_ovr", d[4], 0);
    chk("popush_full", d[3], 1);
    for (int i = 0; i < 16; i++) begin
      rd(4'h0, d);
      chk($sformatf("popush_drain%0d", i), d, (i < 15) ? 32'(8'hE1 + i) : 32'hF0);
    end

    // Enable gating
    rx_pulse(8'h77);
    clk_cpu = 1'b0;
    u_if.sel = 1'b1; u_if.we = 1'b0; u_if.addr = 4'h0;
    u_if.rx_valid = 1'b1; u_if.rx_byte = 8'h99;
    repeat (3) tick();
    u_if.we = 1'b1; u_if.wdata = 32'h12;
    repeat (3) tick();
    u_if.sel = 1'b0; u_if.we = 1'b0; u_if.rx_valid = 1'b0;
    clk_cpu = 1'b1;
    chk("gate_no_tx", u_if.tx_start, 0);
    rd(4'hC, d);
    chk("gate_level", d, 32'h0000_0001);
    rd(4'h0, d);
    chk("gate_data", d, 32'h77);

    // Interrupt
`ifdef UART_CTRL_IRQ_EN
    wr(4'h8, 32'h1);
    chk("irq_quiet", u_if.irq, 0);
    rx_pulse(8'h3C);
    tick();
    chk("irq_set", u_if.irq, 1);
    rd(4'h0, d);
    tick();
    chk("irq_clr", u_if.irq, 0);
    wr(4'h8, 32'h0);
`else
    wr(4'h8, 32'h1);
    rx_pulse(8'h3C);
    tick();
    chk("irq_tied", u_if.irq, 0);
    rd(4'h8, d);
    chk("ctrl_reads_zero", d, 0);
    rd(4'h0, d);
    chk("irq_rx_data", d, 32'h3C);
`endif

    // Randomized traffic against queue models
    m_rx.delete();
    m_ovr = 1'b0;
    tx_exp.delete();
    tx_seen.delete();
    for (int c = 0; c < 800; c++) begin
      op          = $urandom_range(0, 9);
      en          = ($urandom_range(0, 3) != 0);
      rv          = ($urandom_range(0, 9) < 3);
      rb          = 8'($urandom);
      outstanding = tx_exp.size() - tx_seen.size();
      do_wr       = (op == 5) && (outstanding < 8);
      do_clr      = (op == 6) && !rv;
      clk_cpu = en;
      u_if.rx_valid = rv; u_if.rx_byte = rb;
      u_if.sel = 1'b0; u_if.we = 1'b0; u_if.addr = 4'h0; u_if.wdata = $urandom;
      if (op <= 2)     begin u_if.sel = 1'b1; u_if.addr = 4'h0; end
      else if (op == 3) begin u_if.sel = 1'b1; u_if.addr = 4'h4; end
      else if (op == 4) begin u_if.sel = 1'b1; u_if.addr = 4'hC; end
      else if (do_wr)   begin u_if.sel = 1'b1; u_if.we = 1'b1; u_if.addr = 4'h0; end
      else if (do_clr)  begin u_if.sel = 1'b1; u_if.we = 1'b1; u_if.addr = 4'h4; u_if.wdata = 32'h10; end
      #1;
      if (op <= 2)
        chk("rnd_data", u_if.rdata, (m_rx.size() > 0) ? {24'b0, m_rx[0]} : 32'h0);
      else if (op == 3)
        chk("rnd_status", u_if.rdata[4:2], {m_ovr, (m_rx.size() == DEPTH), (m_rx.size() != 0)});
      else if (op == 4)
        chk("rnd_level_rx", u_if.rdata[15:0], m_rx.size());
      if (en) begin
        if (op <= 2 && m_rx.size() > 0) void'(m_rx.pop_front());
        if (rv) begin
          if (m_rx.size() < DEPTH) m_rx.push_back(rb);
          else m_ovr = 1'b1;
        end
        if (do_clr) m_ovr = 1'b0;
        if (do_wr) tx_exp.push_back(u_if.wdata[7:0]);
      end
      tick();
    end
    clk_cpu = 1'b1;
    u_if.sel = 1'b0; u_if.we = 1'b0; u_if.rx_valid = 1'b0;
    wait_tx("rnd_tx_drain", tx_exp.size(), 3000);
    chk("rnd_tx_count", tx_seen.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size(); i++)
      chk($sformatf("rnd_tx%0d", i), seen_at(i), {24'b0, tx_exp[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
